siso: RTL and testbench

- Serial-in/serial-out shift register, default depth 4, with the full register contents visible on a parallel monitor bus `q`.
- Used as a fixed-latency delay line for single-bit streams and as a basic register building block.
- One bit enters per clock; the bit that has been in the register longest leaves on `serial_out`.

---
 rtl/siso_pkg.sv | 11 +
 rtl/siso_stage.sv | 42 ++++
 rtl/siso.sv | 44 ++++
 tb/tb_siso.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared constants and types for the siso shift register.
// Optional feature macro: SISO_SHIFT_ENABLE_EN (adds a shift_en input).
package siso_pkg;

    // Default number of register stages.
    localparam int SISO_DEFAULT_WIDTH = 4;

    // Register vector at the default depth.
    typedef logic [SISO_DEFAULT_WIDTH-1:0] siso_vec_t;

endpackage : siso_pkg

// File: rtl/siso_stage.sv
// One storage stage of the siso shift register: a D flop with asynchronous
// active-low clear. With SISO_SHIFT_ENABLE_EN defined, the stage only loads
// when en=1 and otherwise holds its value.
module siso_stage
    import siso_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef SISO_SHIFT_ENABLE_EN
    input  logic en,
`endif
    input  logic d,
    output logic q
);

    logic bit_d;
    logic bit_q;

    // Next-state select: load the upstream bit, or hold when shifting is paused.
    always_comb begin
        bit_d = bit_q;
`ifdef SISO_SHIFT_ENABLE_EN
        if (en) begin
            bit_d = d;
        end
`else
        bit_d = d;
`endif
    end

    // Storage flop; reset clears without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q = bit_q;

endmodule : siso_stage

// File: rtl/siso.sv
// Serial-in/serial-out shift register with a parallel monitor bus.
// q[0] holds the newest bit, q[WIDTH-1] the oldest; serial_out taps q[WIDTH-1]
// directly from its flop, so it is glitch-free.
// Optional feature macro: SISO_SHIFT_ENABLE_EN adds input shift_en; when it is
// low the whole register holds. Reset always takes priority.
// WIDTH must be at least 2.
module siso
    import siso_pkg::*;
#(
    parameter int WIDTH = SISO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
`ifdef SISO_SHIFT_ENABLE_EN
    input  logic             shift_en,
`endif
    output logic [WIDTH-1:0] q,
    output logic             serial_out
);

    // Input to each stage: stage 0 takes serial_in, stage i takes stage i-1.
    logic [WIDTH-1:0] stage_in;

    // Chain wiring: shift toward the MSB, the old MSB falls off the end.
    always_comb begin
        stage_in = {q[WIDTH-2:0], serial_in};
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        siso_stage u_stage (
            .clk (clk),
            .rst (rst),
`ifdef SISO_SHIFT_ENABLE_EN
            .en  (shift_en),
`endif
            .d   (stage_in[i]),
            .q   (q[i])
        );
    end

    assign serial_out = q[WIDTH-1];

endmodule : siso

// File: tb/tb_siso.sv
// Self-checking bench for siso at the default depth.
// Reference models: a newest-first history queue for the q bus, and an
// edge-indexed input log that predicts serial_out purely from the latency rule.
module tb_siso;
    import siso_pkg::*;

    localparam int W = SISO_DEFAULT_WIDTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic serial_in;
    logic en_tb;
    logic [W-1:0] q;
    logic serial_out;

    always #5 clk = ~clk;

    siso #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
`ifdef SISO_SHIFT_ENABLE_EN
        .shift_en   (en_tb),
`endif
        .q          (q),
        .serial_out (serial_out)
    );

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];   // bits currently held, newest first
    logic [0:0] lat_in[$];  // every bit accepted since the last reset, in order
    int pass_cnt = 0;
    int total    = 0;

    function automatic siso_vec_t model_q();
        siso_vec_t v;
        v = '0;
        for (int i = 0; i < W; i++) begin
            if (i < exp_q.size()) v[i] = exp_q[i];
        end
        return v;
    endfunction

    // serial_out after accepting edge n equals the bit from edge n-W+1 (1-based).
    function automatic logic model_latency_out();
        int n;
        n = lat_in.size();
        if (n >= W) return lat_in[n-W];
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        exp_q.delete();
        lat_in.delete();
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge: drive a bit, take one rising edge, check at the next negedge.
    task automatic shift_bit(input logic b, input string tag);
        serial_in = b;
        @(posedge clk);
        if (en_tb) begin
            exp_q.push_front(b);
            if (exp_q.size() > W) void'(exp_q.pop_back());
            lat_in.push_back(b);
        end
        @(negedge clk);
        check({tag, ".q"}, 32'(q), 32'(model_q()));
        check({tag, ".sout"}, 32'(serial_out), 32'(model_q() >> (W-1)));
        check({tag, ".lat"}, 32'(serial_out), 32'(model_latency_out()));
    endtask

    // Called at a negedge: assert reset between edges and confirm it acts at once.
    task automatic reset_midcycle(input string tag);
        serial_in = 1'b1;
        #2 rst = 1'b0;
        #1;
        check({tag, ".q_now"}, 32'(q), 32'h0);
        check({tag, ".sout_now"}, 32'(serial_out), 32'h0);
        model_clear();
        @(negedge clk);
        check({tag, ".q_clocked"}, 32'(q), 32'h0);
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b0;
        serial_in = 1'b1;
        en_tb     = 1'b1;
        model_clear();

        // Reset held across clock edges.
        @(negedge clk);
        @(negedge clk);
        check("por.q", 32'(q), 32'h0);
        check("por.sout", 32'(serial_out), 32'h0);
        rst = 1'b1;

        // Single bit walking to the MSB and out.
        shift_bit(1'b1, "walk0");
        check("walk0.const", 32'(q), 32'h1);
        for (int i = 1; i <= W; i++) shift_bit(1'b0, $sformatf("walk%0d", i));
        check("walk.end", 32'(q), 32'h0);

        // Pattern 1,0,1,1 then drain.
        shift_bit(1'b1, "pat0");
        shift_bit(1'b0, "pat1");
        shift_bit(1'b1, "pat2");
        shift_bit(1'b1, "pat3");
        check("pat.load", 32'(q), 32'hB);
        for (int i = 0; i < W; i++) shift_bit(1'b0, $sformatf("drain%0d", i));

        // Reset mid-stream from 1101.
        shift_bit(1'b1, "mid0");
        shift_bit(1'b1, "mid1");
        shift_bit(1'b0, "mid2");
        shift_bit(1'b1, "mid3");
        check("mid.load", 32'(q), 32'hD);
        reset_midcycle("midrst");
        shift_bit(1'b1, "after_rst");
        check("after_rst.const", 32'(q), 32'h1);

        // Random stream of 25 bits from a clean reset.
        reset_midcycle("rnd_rst");
        for (int i = 0; i < 25; i++) shift_bit(1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));

`ifdef SISO_SHIFT_ENABLE_EN
        // Hold with shift_en low, then one enabled shift.
        shift_bit(1'b0, "en_ld0");
        shift_bit(1'b1, "en_ld1");
        shift_bit(1'b1, "en_ld2");
        shift_bit(1'b0, "en_ld3");
        check("en.load", 32'(q), 32'h6);
        en_tb = 1'b0;
        for (int i = 0; i < 3; i++) shift_bit(1'b1, $sformatf("hold%0d", i));
        check("en.hold", 32'(q), 32'h6);
        en_tb = 1'b1;
        shift_bit(1'b1, "en_go");
        check("en.go", 32'(q), 32'hD);
        // Reset overrides a disabled shift.
        en_tb = 1'b0;
        reset_midcycle("en_rst");
        en_tb = 1'b1;
`endif

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule : tb_siso
